if_stage: RTL and testbench
===========================

// Module: if_stage
// PURPOSE
//   Instruction-fetch stage for the pipelined LoongArch core; feeds the decode (ID) stage.
//   Generates nextpc (pre-IF) and drives the synchronous inst SRAM (1-cycle read latency).
//   Holds the fetched PC/instruction and hands it to ID with a valid/allowin handshake.
//   Redirects on branch/jump from ID, squashing the wrong-path instruction.
// PARAMETERS
//   RESET_PC  32'h1c000000  address of the first instruction fetched after reset
// PORTS
//   clk              in   1   clock; all state updates on posedge
//   reset            in   1   synchronous, active-high reset
//   ds_allowin       in   1   ID can accept an instruction this cycle
//   br_taken         in   1   redirect request from ID (one-cycle pulse)
//   br_target        in   32  redirect address, valid with br_taken
//   fs_to_ds_valid   out  1   fs_to_ds_pc/inst valid for ID
//   fs_to_ds_pc      out  32  PC of the instruction in IF
//   fs_to_ds_inst    out  32  instruction word in IF
//   inst_sram_en     out  1   SRAM read enable
//   inst_sram_we     out  4   byte write enables, tied 4'h0
//   inst_sram_addr   out  32  SRAM address (= nextpc)
//   inst_sram_wdata  out  32  tied 32'h0
//   inst_sram_rdata  in   32  read data, valid the cycle after en&addr
// BEHAVIOUR
//   Reset: fs_valid=0, fs_pc=RESET_PC-4, br_pending=0, buf_valid=0.
//     Outputs during reset: fs_to_ds_valid=0, inst_sram_en=0.
//   Handshake terms:
//     fs_ready_go = 1.
//     fs_allowin = ~fs_valid | (fs_ready_go & ds_allowin).
//     to_fs_valid = ~reset.
//   nextpc priority: br_taken ? br_target : br_pending ? pend_target : fs_pc+4.
//     Arithmetic is mod 2^32: 0xfffffffc+4 -> 0x00000000. Low 2 bits of target are passed unchanged.
//   inst_sram_en = to_fs_valid & fs_allowin; inst_sram_addr = nextpc every cycle.
//   Load: when to_fs_valid & fs_allowin, fs_valid<=1, fs_pc<=nextpc, br_pending<=0, buf_valid<=0.
//     The instruction is on inst_sram_rdata in the next cycle (1-cycle latency).
//   Drain only: when fs_valid & ds_allowin and no load occurs, fs_valid<=0.
//   fs_to_ds_valid = fs_valid & ~br_taken. The wrong-path instruction is never presented to ID.
//   fs_to_ds_inst = buf_valid ? inst_buf : inst_sram_rdata; fs_to_ds_pc = fs_pc.
//   Stall buffer: if fs_valid & ~ds_allowin & ~buf_valid, then inst_buf<=inst_sram_rdata and buf_valid<=1.
//     fs_to_ds_inst stays constant for the whole stall. Undefined SRAM hold behaviour is not relied on.
//   Redirect with fs_allowin=1: fs loads br_target directly and the old fs entry is discarded.
//     The instruction at br_target reaches ID 1 cycle after the br_taken cycle.
//   Redirect with fs_allowin=0: fs_valid<=0, buf_valid<=0, br_pending<=1, pend_target<=br_target.
//     In the next cycle fs_allowin=1 and nextpc=pend_target.
//   A new br_taken while br_pending=1 overrides pend_target (latest redirect wins).
//   Back-to-back br_taken on consecutive cycles is legal. Each one squashes the current fs entry.
//   Reset asserted mid-operation: all state returns to reset values in the same edge.
//     Any pending redirect and any buffered instruction are lost.
//     First fetch after reset deasserts is RESET_PC.
//   Throughput: 1 instruction per cycle with ds_allowin held high. No bubble except on redirect.
// TESTING
//   Reset 3 cycles, then release, ds_allowin=1.
//     -> inst_sram_addr 0x1c000000, 0x1c000004, ...
//     -> fs_to_ds_pc trails inst_sram_addr by 1 cycle; fs_to_ds_valid high from the 2nd cycle.
//   At pc 0x1c000008, ds_allowin=0 for 3 cycles while the SRAM model returns garbage.
//     -> inst_sram_en=0; fs_to_ds_inst/pc are held at the 0x1c000008 word.
//     -> Resumes at 0x1c00000c with no duplicate and no skip.
//   br_taken=1, br_target=0x1c000100, ds_allowin=1, fs at 0x1c000010.
//     -> fs_to_ds_valid=0 that cycle; next fs_to_ds_pc=0x1c000100.
//     -> 0x1c000010 is never accepted by ID.
//   br_taken with target 0x1c000200 while ds_allowin=0.
//     -> br_pending=1; next cycle inst_sram_addr=0x1c000200, en=1.
//     -> Then target 0x1c000300 arriving while pending takes precedence.
//   Force fs_pc near 0xfffffffc and run sequentially.
//     -> next inst_sram_addr=0x00000000.
//   Assert reset during a stall with br_pending=1.
//     -> All state cleared; after release the first address is 0x1c000000.
//     -> No wrong-path fs_to_ds_valid.

Source files
------------

// File: rtl/if_stage.sv
// Instruction-fetch stage: generates nextpc, drives the inst SRAM and
// hands the fetched PC/instruction to ID with a valid/allowin handshake.
module if_stage #(
  parameter logic [31:0] RESET_PC = 32'h1c000000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ds_allowin,
  input  logic        br_taken,
  input  logic [31:0] br_target,
  output logic        fs_to_ds_valid,
  output logic [31:0] fs_to_ds_pc,
  output logic [31:0] fs_to_ds_inst,
  output logic        inst_sram_en,
  output logic [3:0]  inst_sram_we,
  output logic [31:0] inst_sram_addr,
  output logic [31:0] inst_sram_wdata,
  input  logic [31:0] inst_sram_rdata
);

  logic        fs_valid;
  logic [31:0] fs_pc;
  logic        br_pending;
  logic [31:0] pend_target;
  logic        buf_valid;
  logic [31:0] inst_buf;

  logic        fs_ready_go;
  logic        fs_allowin;
  logic        to_fs_valid;
  logic        fs_load;
  logic [31:0] seq_pc;
  logic [31:0] nextpc;

  assign fs_ready_go = 1'b1;
  assign fs_allowin  = ~fs_valid | (fs_ready_go & ds_allowin);
  assign to_fs_valid = ~reset;
  assign fs_load     = to_fs_valid & fs_allowin;
  assign seq_pc      = fs_pc + 32'd4;

  // Redirect from ID beats a parked redirect, which beats sequential fetch.
  always_comb begin
    nextpc = seq_pc;
    if (br_taken) begin
      nextpc = br_target;
    end else if (br_pending) begin
      nextpc = pend_target;
    end
  end

  assign inst_sram_en    = fs_load;
  assign inst_sram_we    = 4'h0;
  assign inst_sram_addr  = nextpc;
  assign inst_sram_wdata = 32'h0;

  // Gated with reset so a stale entry cannot leak out during reset.
  assign fs_to_ds_valid = fs_valid & ~br_taken & ~reset;
  assign fs_to_ds_pc    = fs_pc;
  assign fs_to_ds_inst  = buf_valid ? inst_buf : inst_sram_rdata;

  // IF entry, parked redirect and stall buffer.
  always_ff @(posedge clk) begin
    if (reset) begin
      fs_valid    <= 1'b0;
      fs_pc       <= RESET_PC - 32'd4;
      br_pending  <= 1'b0;
      pend_target <= 32'h0;
      buf_valid   <= 1'b0;
      inst_buf    <= 32'h0;
    end else if (fs_load) begin
      fs_valid   <= 1'b1;
      fs_pc      <= nextpc;
      br_pending <= 1'b0;
      buf_valid  <= 1'b0;
    end else if (br_taken) begin
      fs_valid    <= 1'b0;
      buf_valid   <= 1'b0;
      br_pending  <= 1'b1;
      pend_target <= br_target;
    end else begin
      if (fs_valid & ds_allowin) begin
        fs_valid <= 1'b0;
      end
      if (fs_valid & ~ds_allowin & ~buf_valid) begin
        inst_buf  <= inst_sram_rdata;
        buf_valid <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage with a 1-cycle-latency SRAM model
// that returns random garbage whenever it is not enabled.
module tb_if_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        ds_allowin;
  logic        br_taken;
  logic [31:0] br_target;
  logic        fs_to_ds_valid;
  logic [31:0] fs_to_ds_pc;
  logic [31:0] fs_to_ds_inst;
  logic        inst_sram_en;
  logic [3:0]  inst_sram_we;
  logic [31:0] inst_sram_addr;
  logic [31:0] inst_sram_wdata;
  logic [31:0] inst_sram_rdata;

  int n_checks = 0;
  int n_fail   = 0;

  if_stage dut (
    .clk             (clk),
    .reset           (reset),
    .ds_allowin      (ds_allowin),
    .br_taken        (br_taken),
    .br_target       (br_target),
    .fs_to_ds_valid  (fs_to_ds_valid),
    .fs_to_ds_pc     (fs_to_ds_pc),
    .fs_to_ds_inst   (fs_to_ds_inst),
    .inst_sram_en    (inst_sram_en),
    .inst_sram_we    (inst_sram_we),
    .inst_sram_addr  (inst_sram_addr),
    .inst_sram_wdata (inst_sram_wdata),
    .inst_sram_rdata (inst_sram_rdata)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] word(input logic [31:0] a);
    return a ^ 32'h5a5a_5a5a;
  endfunction

  // SRAM model
  always @(posedge clk) begin
    if (inst_sram_en) inst_sram_rdata <= word(inst_sram_addr);
    else              inst_sram_rdata <= $urandom;
  end

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic rst, input logic al,
                       input logic br, input logic [31:0] tgt);
    @(negedge clk);
    reset      = rst;
    ds_allowin = al;
    br_taken   = br;
    br_target  = tgt;
    #1;
  endtask

  task automatic chk_out(input string tag, input logic v,
                         input logic en, input logic [31:0] addr);
    chk({tag, ".valid"}, {31'h0, fs_to_ds_valid}, {31'h0, v});
    chk({tag, ".en"}, {31'h0, inst_sram_en}, {31'h0, en});
    chk({tag, ".addr"}, inst_sram_addr, addr);
  endtask

  task automatic chk_fs(input string tag, input logic [31:0] pc);
    chk({tag, ".pc"}, fs_to_ds_pc, pc);
    chk({tag, ".inst"}, fs_to_ds_inst, word(pc));
  endtask

  initial begin
    reset = 1'b1; ds_allowin = 1'b1; br_taken = 1'b0; br_target = '0;
    for (int i = 0; i < 3; i++) begin
      drive(1, 1, 0, 0);
      chk("rst.valid", {31'h0, fs_to_ds_valid}, 32'h0);
      chk("rst.en", {31'h0, inst_sram_en}, 32'h0);
    end
    chk("rst.we", {28'h0, inst_sram_we}, 32'h0);
    chk("rst.wdata", inst_sram_wdata, 32'h0);

    drive(0, 1, 0, 0); chk_out("seqA", 0, 1, 32'h1c000000);
    drive(0, 1, 0, 0); chk_out("seqB", 1, 1, 32'h1c000004);
    chk_fs("seqB", 32'h1c000000);
    drive(0, 1, 0, 0); chk_out("seqC", 1, 1, 32'h1c000008);
    chk_fs("seqC", 32'h1c000004);

    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 0, 0);
      chk_out("stall", 1, 0, 32'h1c00000c);
      chk_fs("stall", 32'h1c000008);
    end
    drive(0, 1, 0, 0); chk_out("resume", 1, 1, 32'h1c00000c);
    chk_fs("resume", 32'h1c000008);
    drive(0, 1, 0, 0); chk_out("next", 1, 1, 32'h1c000010);
    chk_fs("next", 32'h1c00000c);

    drive(0, 1, 1, 32'h1c000100);
    chk_out("br", 0, 1, 32'h1c000100);
    chk("br.pc", fs_to_ds_pc, 32'h1c000010);
    drive(0, 1, 0, 0); chk_out("brT", 1, 1, 32'h1c000104);
    chk_fs("brT", 32'h1c000100);

    drive(0, 0, 1, 32'h1c000200);
    chk_out("brst", 0, 0, 32'h1c000200);
    drive(0, 0, 0, 0); chk_out("pend", 0, 1, 32'h1c000200);
    drive(0, 0, 0, 0); chk_out("pendT", 1, 0, 32'h1c000204);
    chk_fs("pendT", 32'h1c000200);
    drive(0, 0, 1, 32'h1c000280);
    chk_out("pend2", 0, 0, 32'h1c000280);
    drive(0, 0, 1, 32'h1c000300);
    chk_out("ovr", 0, 1, 32'h1c000300);
    drive(0, 1, 0, 0); chk_out("ovrT", 1, 1, 32'h1c000304);
    chk_fs("ovrT", 32'h1c000300);

    drive(0, 1, 1, 32'hfffffff8);
    chk_out("wrapBr", 0, 1, 32'hfffffff8);
    drive(0, 1, 0, 0); chk_out("wrap1", 1, 1, 32'hfffffffc);
    drive(0, 1, 0, 0); chk_out("wrap2", 1, 1, 32'h00000000);
    chk_fs("wrap2", 32'hfffffffc);
    drive(0, 1, 0, 0); chk_out("wrap3", 1, 1, 32'h00000004);
    chk_fs("wrap3", 32'h00000000);

    drive(0, 0, 1, 32'h1c000400);
    chk_out("rbr", 0, 0, 32'h1c000400);
    drive(1, 0, 0, 0);
    chk("rmid.valid", {31'h0, fs_to_ds_valid}, 32'h0);
    chk("rmid.en", {31'h0, inst_sram_en}, 32'h0);
    drive(0, 1, 0, 0); chk_out("rel", 0, 1, 32'h1c000000);
    drive(0, 1, 0, 0); chk_out("rel2", 1, 1, 32'h1c000004);
    chk_fs("rel2", 32'h1c000000);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
